// File: rtl/pal_csync_generator_pkg.sv
// PAL composite sync generator: shared types and defaults.
// Vertical sequence state encoding and PAL half-line counts.
package pal_csync_generator_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'b00,
        ST_PRE_EQ  = 2'b01,
        ST_VSYNC   = 2'b10,
        ST_POST_EQ = 2'b11
    } vstate_e;

    localparam int DEF_CNT_W        = 11;
    localparam int DEF_HS_WIDTH     = 64;
    localparam int DEF_EQ_WIDTH     = 32;
    localparam int PAL_PRE_EQ_HALF  = 5;
    localparam int PAL_VS_HALF      = 5;
    localparam int PAL_POST_EQ_HALF = 5;
    localparam int DEF_BURST_START  = 72;
    localparam int DEF_BURST_LEN    = 40;
    localparam int HC_W             = 4;

    function automatic vstate_e next_vstate(input vstate_e s);
        vstate_e n;
        n = ST_NORMAL;
        case (s)
            ST_NORMAL: n = ST_PRE_EQ;
            ST_PRE_EQ: n = ST_VSYNC;
            ST_VSYNC:  n = ST_POST_EQ;
            default:   n = ST_NORMAL;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pal_edge_sync.sv
// Two-flop synchroniser with a registered falling-edge pulse.
// Sync flops reset high so an input held low at release reads as a fall.
module pal_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic fall_q;

    // Synchronise, then flag the 1->0 step as it moves into the second stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            fall_q <= s2_q & ~s1_q;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/pal_csync_generator.sv
// Regenerates PAL composite sync with equalising/broad pulses from HS/FSn,
// plus burst gate, vertical blank, line-length measurement and lock flag.
module pal_csync_generator
    import pal_csync_generator_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int HS_WIDTH     = DEF_HS_WIDTH,
    parameter int EQ_WIDTH     = DEF_EQ_WIDTH,
    parameter int PRE_EQ_HALF  = PAL_PRE_EQ_HALF,
    parameter int VS_HALF      = PAL_VS_HALF,
    parameter int POST_EQ_HALF = PAL_POST_EQ_HALF,
    parameter int BURST_START  = DEF_BURST_START,
    parameter int BURST_LEN    = DEF_BURST_LEN
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             HS,
    input  logic             FSn,
    output logic             CSYNCn,
    output logic             BURST,
    output logic             VBLANK,
    output logic             LOCKED,
    output logic [CNT_W-1:0] LINE_LEN
);

    localparam logic [CNT_W-1:0] POS_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] HS_W    = CNT_W'(HS_WIDTH);
    localparam logic [CNT_W-1:0] EQ_W    = CNT_W'(EQ_WIDTH);
    localparam logic [CNT_W-1:0] B_LO    = CNT_W'(BURST_START);
    localparam logic [CNT_W-1:0] B_HI    = CNT_W'(BURST_START + BURST_LEN);
    localparam logic [HC_W-1:0]  HC_PRE  = HC_W'(PRE_EQ_HALF);
    localparam logic [HC_W-1:0]  HC_VS   = HC_W'(VS_HALF);
    localparam logic [HC_W-1:0]  HC_POST = HC_W'(POST_EQ_HALF);

    logic             hs_fall;
    logic             fs_fall;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] tpos_q, tpos_d;
    logic [CNT_W-1:0] len_new;
    logic [CNT_W:0]   len_diff;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] broad_w;
    logic             len_close;
    logic             sat;
    logic             tick;
    logic             locked_q, locked_d;
    logic             seen_q, seen_d;
    logic             arm_q, arm_d;
    vstate_e          state_q, state_d;
    logic [HC_W-1:0]  hc_q, hc_d;
    logic [HC_W-1:0]  hc_lim;
    logic             cs_low;
    logic             csync_q, csync_d;
    logic             burst_q, burst_d;
    logic             vblank_q, vblank_d;

    pal_edge_sync u_hs_sync (
        .clk_i  (CLK),
        .rst_ni (RESETn),
        .d_i    (HS),
        .fall_o (hs_fall)
    );

    pal_edge_sync u_fs_sync (
        .clk_i  (CLK),
        .rst_ni (RESETn),
        .d_i    (FSn),
        .fall_o (fs_fall)
    );

    // One extra bit keeps the +/-1 test from wrapping around zero.
    assign sat       = (pos_q == POS_MAX);
    assign len_new   = pos_q + CNT_W'(1);
    assign len_diff  = {1'b0, len_new} - {1'b0, len_q};
    assign len_close = (len_diff == '0)
                    || (len_diff == (CNT_W+1)'(1))
                    || (len_diff == '1);
    assign half      = len_q >> 1;
    assign broad_w   = (half > HS_W) ? (half - HS_W) : '0;

    // Line position counter, line length capture and lock detection.
    always_comb begin
        pos_d    = pos_q;
        len_d    = len_q;
        locked_d = locked_q;
        seen_d   = seen_q;
        if (hs_fall) begin
            pos_d    = '0;
            len_d    = len_new;
            seen_d   = 1'b1;
            locked_d = !sat && len_close;
        end else begin
            if (!sat) begin
                pos_d = pos_q + CNT_W'(1);
            end
            if (pos_d == POS_MAX) begin
                locked_d = 1'b0;
            end
        end
    end

    // A fall coinciding with mid-line yields a single tick.
    assign tick = hs_fall || ((len_q != '0) && (pos_d == half));

    // Distance from the most recent half-line tick.
    always_comb begin
        tpos_d = tpos_q;
        if (tick) begin
            tpos_d = '0;
        end else if (tpos_q != POS_MAX) begin
            tpos_d = tpos_q + CNT_W'(1);
        end
    end

    // Half-line count that ends each vertical state.
    always_comb begin
        hc_lim = '0;
        case (state_q)
            ST_PRE_EQ:  hc_lim = HC_PRE;
            ST_VSYNC:   hc_lim = HC_VS;
            ST_POST_EQ: hc_lim = HC_POST;
            default:    hc_lim = '0;
        endcase
    end

    // Vertical sequence FSM: arm on FSn, start on the next HS fall.
    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        arm_d   = arm_q;
        unique case (state_q)
            ST_NORMAL: begin
                if (hs_fall && arm_q) begin
                    state_d = ST_PRE_EQ;
                    hc_d    = HC_W'(1);
                    arm_d   = 1'b0;
                end else if (fs_fall && !arm_q && locked_q) begin
                    arm_d = 1'b1;
                end
            end
            ST_PRE_EQ, ST_VSYNC, ST_POST_EQ: begin
                if (tick) begin
                    if (hc_q == hc_lim) begin
                        state_d = next_vstate(state_q);
                        hc_d    = (state_d == ST_NORMAL) ? '0 : HC_W'(1);
                    end else begin
                        hc_d = hc_q + HC_W'(1);
                    end
                end
            end
        endcase
    end

    // Pulse shaping from next-state values so outputs register in one step.
    always_comb begin
        cs_low = 1'b0;
        unique case (state_d)
            ST_NORMAL:  cs_low = seen_d && (pos_d < HS_W);
            ST_VSYNC:   cs_low = tpos_d < broad_w;
            ST_PRE_EQ:  cs_low = tpos_d < EQ_W;
            ST_POST_EQ: cs_low = tpos_d < EQ_W;
        endcase
        csync_d  = ~cs_low;
        burst_d  = seen_d && (state_d == ST_NORMAL) && !arm_d
                && (pos_d >= B_LO) && (pos_d < B_HI);
        vblank_d = arm_d || (state_d != ST_NORMAL);
    end

    // Measurement and tick-distance state.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            pos_q    <= '0;
            len_q    <= '0;
            tpos_q   <= '0;
            locked_q <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            len_q    <= len_d;
            tpos_q   <= tpos_d;
            locked_q <= locked_d;
            seen_q   <= seen_d;
        end
    end

    // Vertical sequence state.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= ST_NORMAL;
            hc_q    <= '0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            arm_q   <= arm_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            csync_q  <= 1'b1;
            burst_q  <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            csync_q  <= csync_d;
            burst_q  <= burst_d;
            vblank_q <= vblank_d;
        end
    end

    assign CSYNCn   = csync_q;
    assign BURST    = burst_q;
    assign VBLANK   = vblank_q;
    assign LOCKED   = locked_q;
    assign LINE_LEN = len_q;

endmodule
